// File: rtl/digit_scroll_display.sv
// digit_scroll_display: stores a stream of BCD digits and pages through them on
// NUM_HEX seven-segment displays. The left IDX_DIGITS displays show the decimal page
// number, and the right DPP displays show that page's digits. Paging can be automatic
// or manual, in either direction.
module digit_scroll_display #(
    parameter int MAX_DIGITS  = 150,
    parameter int AW          = 8,
    parameter int NUM_HEX     = 6,
    parameter int IDX_DIGITS  = 2,
    parameter int TICK_CYCLES = 50_000_000
) (
    input  logic                 CLOCK_50,
    input  logic                 rst,
    input  logic                 wr_clear,
    input  logic                 wr_valid,
    input  logic [3:0]           wr_digit,
    input  logic                 wr_done,
    input  logic                 run,
    input  logic                 step,
    input  logic                 dir,
    output logic [7*NUM_HEX-1:0] hex,
    output logic [AW-1:0]        page,
    output logic [AW:0]          count,
    output logic                 overflow,
    output logic                 showing
);

    localparam int DPP     = NUM_HEX - IDX_DIGITS;
    localparam int TW      = $clog2(TICK_CYCLES);
    localparam int IDX_MOD = 10 ** IDX_DIGITS;

    typedef enum logic [1:0] {LOAD, SCROLL, PAUSE} state_t;

    state_t               state_q, state_d;
    logic [AW:0]          count_q, count_d;
    logic [AW-1:0]        page_q, page_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic                 overflow_q, overflow_d;
    logic [7*NUM_HEX-1:0] hex_q, hex_d;
    logic                 wr_en;
    logic [AW-1:0]        last_page;
    logic [3:0]           mem_q [MAX_DIGITS];

    // Active-low segment pattern for one BCD digit. Codes 10..15 are shown blank.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    // Move one page in the requested direction, wrapping at either end.
    // When there is only one page (last == 0), the page stays at 0.
    function automatic logic [AW-1:0] next_page(input logic [AW-1:0] p, input logic back,
                                                input logic [AW-1:0] last);
        if (back) next_page = (p == '0) ? last : p - AW'(1);
        else      next_page = (p == last) ? '0 : p + AW'(1);
    endfunction

    // Index of the last page. There is always at least one page, even with an empty buffer.
    always_comb begin
        last_page = '0;
        if (count_q != '0)
            last_page = AW'((count_q - (AW+1)'(1)) / (AW+1)'(DPP));
    end

    // Next-state logic: loading, auto-scroll timing, manual stepping and clear.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        page_d     = page_q;
        tick_d     = tick_q;
        overflow_d = overflow_q;
        wr_en      = 1'b0;
        if (wr_clear) begin
            state_d    = LOAD;
            count_d    = '0;
            page_d     = '0;
            tick_d     = '0;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (wr_valid) begin
                        if (count_q < (AW+1)'(MAX_DIGITS)) begin
                            wr_en   = 1'b1;
                            count_d = count_q + (AW+1)'(1);
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                    if (wr_done) begin
                        page_d  = '0;
                        tick_d  = '0;
                        state_d = run ? SCROLL : PAUSE;
                    end
                end
                SCROLL: begin
                    if (!run) begin
                        state_d = PAUSE;
                    end else if (tick_q == TW'(TICK_CYCLES - 1)) begin
                        tick_d = '0;
                        page_d = next_page(page_q, dir, last_page);
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                PAUSE: begin
                    if (step) page_d = next_page(page_q, dir, last_page);
                    if (run)  state_d = SCROLL;
                end
                default: state_d = LOAD;
            endcase
        end
    end

    // Display image for the current page or load progress.
    // Digits at or beyond count are shown blank, so stale buffer contents never appear.
    always_comb begin
        int a;
        int iv;
        hex_d = '1;
        a     = 0;
        for (int k = 0; k < DPP; k++) begin
            a = int'(page_q) * DPP + (DPP - 1 - k);
            if (state_q != LOAD && a < int'(count_q))
                hex_d[7*k +: 7] = seg7(mem_q[a[AW-1:0]]);
        end
        iv = (state_q == LOAD) ? int'(count_q) : int'(page_q);
        iv = iv % IDX_MOD;
        for (int k = 0; k < IDX_DIGITS; k++)
            hex_d[7*(DPP+k) +: 7] = seg7(4'((iv / (10 ** k)) % 10));
    end

    // Control and display registers. The reset is asynchronous.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            state_q    <= LOAD;
            count_q    <= '0;
            page_q     <= '0;
            tick_q     <= '0;
            overflow_q <= 1'b0;
            hex_q      <= '1;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            page_q     <= page_d;
            tick_q     <= tick_d;
            overflow_q <= overflow_d;
            hex_q      <= hex_d;
        end
    end

    // Digit buffer. It is not reset; count alone defines which entries are valid.
    always_ff @(posedge CLOCK_50) begin
        if (wr_en) mem_q[count_q[AW-1:0]] <= wr_digit;
    end

    assign hex      = hex_q;
    assign page     = page_q;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign showing  = (state_q != LOAD);

endmodule

// File: tb/tb_digit_scroll_display.sv
// Directed bench for digit_scroll_display with a short auto-scroll period.
// Expectations are queued as stimulus is applied and drained against the outputs.
module tb_digit_scroll_display;

    localparam int AW = 8;
    localparam int NUM_HEX = 6;

    logic                 CLOCK_50;
    logic                 rst;
    logic                 wr_clear;
    logic                 wr_valid;
    logic [3:0]           wr_digit;
    logic                 wr_done;
    logic                 run;
    logic                 step;
    logic                 dir;
    logic [7*NUM_HEX-1:0] hex;
    logic [AW-1:0]        page;
    logic [AW:0]          count;
    logic                 overflow;
    logic                 showing;

    digit_scroll_display #(
        .MAX_DIGITS(150), .AW(AW), .NUM_HEX(NUM_HEX), .IDX_DIGITS(2), .TICK_CYCLES(4)
    ) dut (
        .CLOCK_50(CLOCK_50), .rst(rst), .wr_clear(wr_clear), .wr_valid(wr_valid),
        .wr_digit(wr_digit), .wr_done(wr_done), .run(run), .step(step), .dir(dir),
        .hex(hex), .page(page), .count(count), .overflow(overflow), .showing(showing)
    );

    typedef struct {
        string       tag;
        int          kind;
        logic [63:0] exp;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    localparam int K_PAGE = 0, K_COUNT = 1, K_HEX = 2, K_OVF = 3, K_SHOW = 4;
    localparam int BL = 15;

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [6:0] sg(input int d);
        case (d)
            0: sg = 7'h40;  1: sg = 7'h79;  2: sg = 7'h24;  3: sg = 7'h30;
            4: sg = 7'h19;  5: sg = 7'h12;  6: sg = 7'h02;  7: sg = 7'h78;
            8: sg = 7'h00;  9: sg = 7'h10;
            default: sg = 7'h7F;
        endcase
    endfunction

    // Arguments are the page index, then digits from the leftmost to the rightmost
    // value display. BL marks a display that should be blank.
    function automatic logic [41:0] hp(input int idx, input int a, input int b,
                                       input int c, input int d);
        hp = {sg((idx / 10) % 10), sg(idx % 10), sg(a), sg(b), sg(c), sg(d)};
    endfunction

    task automatic push(input string tag, input int kind, input logic [63:0] v);
        exp_t e;
        e.tag = tag; e.kind = kind; e.exp = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [63:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                K_PAGE:  obs = 64'(page);
                K_COUNT: obs = 64'(count);
                K_HEX:   obs = 64'(hex);
                K_OVF:   obs = 64'(overflow);
                default: obs = 64'(showing);
            endcase
            total++;
            assert (obs === e.exp) else begin
                bad++;
                $error("FAIL %s: observed=%0h expected=%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic clk(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic push_reset(input string tag);
        push({tag, "_hex"}, K_HEX, {22'd0, {42{1'b1}}});
        push({tag, "_page"}, K_PAGE, 64'd0);
        push({tag, "_count"}, K_COUNT, 64'd0);
        push({tag, "_ovf"}, K_OVF, 64'd0);
        push({tag, "_show"}, K_SHOW, 64'd0);
    endtask

    int d9 [9] = '{2, 7, 1, 8, 2, 8, 1, 8, 2};

    initial begin
        rst = 1'b1; wr_clear = 0; wr_valid = 0; wr_digit = 0; wr_done = 0;
        run = 0; step = 0; dir = 0;
        #3;
        push_reset("rst");
        drain();
        clk(2);
        rst = 1'b0;

        // 1: load 9 digits with wr_done on the last one, then auto-scroll forward
        run = 1; dir = 0;
        for (int i = 0; i < 9; i++) begin
            wr_valid = 1; wr_digit = 4'(d9[i]); wr_done = (i == 8);
            clk(1);
        end
        wr_valid = 0; wr_done = 0;
        push("t1_page0", K_PAGE, 64'd0);
        push("t1_count", K_COUNT, 64'd9);
        push("t1_show", K_SHOW, 64'd1);
        push("t1_loadhex", K_HEX, 64'(hp(8, BL, BL, BL, BL)));
        drain();
        clk(1); push("t1_hex0", K_HEX, 64'(hp(0, 2, 7, 1, 8))); drain();
        clk(3); push("t1_page1", K_PAGE, 64'd1); drain();
        clk(1); push("t1_hex1", K_HEX, 64'(hp(1, 2, 8, 1, 8))); drain();
        clk(3); push("t1_page2", K_PAGE, 64'd2); drain();
        clk(1); push("t1_hex2", K_HEX, 64'(hp(2, 2, BL, BL, BL))); drain();
        clk(3); push("t1_wrap", K_PAGE, 64'd0); drain();

        // 2: backward auto-scroll wraps from page 0 to the last page
        dir = 1;
        clk(4); push("t2_p2", K_PAGE, 64'd2); drain();
        clk(4); push("t2_p1", K_PAGE, 64'd1); drain();
        clk(4); push("t2_p0", K_PAGE, 64'd0); drain();

        // 3: pause with tick=2, single-step, then resume from the held tick
        dir = 0;
        clk(2); push("t3_hexp0", K_HEX, 64'(hp(0, 2, 7, 1, 8))); drain();
        run = 0;
        clk(1);
        clk(100); push("t3_hold", K_PAGE, 64'd0); push("t3_show", K_SHOW, 64'd1); drain();
        step = 1; clk(1); step = 0;
        push("t3_step", K_PAGE, 64'd1); drain();
        run = 1;
        clk(1); push("t3_res0", K_PAGE, 64'd1); drain();
        clk(1); push("t3_res1", K_PAGE, 64'd1); drain();
        clk(1); push("t3_adv", K_PAGE, 64'd2); drain();
        step = 1; clk(1); step = 0;
        push("t3_stepign", K_PAGE, 64'd2); drain();

        // 4: overfill the buffer, then view the partial last page
        wr_clear = 1; clk(1); wr_clear = 0;
        push("t4_clrcnt", K_COUNT, 64'd0); push("t4_clrshow", K_SHOW, 64'd0); drain();
        run = 0;
        for (int i = 0; i < 152; i++) begin
            wr_valid = 1; wr_digit = 4'(i % 10);
            clk(1);
        end
        wr_valid = 0;
        push("t4_count", K_COUNT, 64'd150); push("t4_ovf", K_OVF, 64'd1); drain();
        clk(1); push("t4_loadhex", K_HEX, 64'(hp(50, BL, BL, BL, BL))); drain();
        wr_done = 1; clk(1); wr_done = 0;
        push("t4_show", K_SHOW, 64'd1); push("t4_page0", K_PAGE, 64'd0); drain();
        wr_valid = 1; wr_digit = 4'd7; clk(1); wr_valid = 0;
        push("t4_wrign", K_COUNT, 64'd150); drain();
        dir = 1; step = 1; clk(1); step = 0;
        push("t4_last", K_PAGE, 64'd37); drain();
        clk(1); push("t4_lasthex", K_HEX, 64'(hp(37, 8, 9, BL, BL))); drain();
        dir = 0; step = 1; clk(1); step = 0;
        push("t4_fwrap", K_PAGE, 64'd0); drain();
        clk(1); push("t4_hex0", K_HEX, 64'(hp(0, 0, 1, 2, 3))); drain();

        // 5: a clear and a write in the same cycle during SCROLL; the clear wins
        run = 1; clk(1);
        push("t5_scroll", K_SHOW, 64'd1); drain();
        wr_clear = 1; wr_valid = 1; wr_digit = 4'd5; clk(1);
        wr_clear = 0; wr_valid = 0;
        push("t5_count", K_COUNT, 64'd0); push("t5_show", K_SHOW, 64'd0);
        push("t5_ovf", K_OVF, 64'd0); push("t5_page", K_PAGE, 64'd0); drain();
        clk(1); push("t5_hex", K_HEX, 64'(hp(0, BL, BL, BL, BL))); drain();
        wr_valid = 1; wr_digit = 4'd3; clk(1); wr_valid = 0;
        push("t5_cnt1", K_COUNT, 64'd1); drain();
        run = 0; wr_done = 1; clk(1); wr_done = 0;
        clk(1); push("t5_buf0", K_HEX, 64'(hp(0, 3, BL, BL, BL))); drain();

        // 6: asynchronous reset during a scroll, then wr_done with an empty buffer
        wr_clear = 1; clk(1); wr_clear = 0;
        run = 1;
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1; wr_digit = 4'(i % 10); wr_done = (i == 15);
            clk(1);
        end
        wr_valid = 0; wr_done = 0;
        clk(12); push("t6_p3", K_PAGE, 64'd3); drain();
        clk(1); push("t6_hex3", K_HEX, 64'(hp(3, 2, 3, 4, 5))); drain();
        #2; rst = 1; #1;
        push_reset("t6_async");
        drain();
        clk(1); rst = 0;
        wr_done = 1; clk(1); wr_done = 0;
        push("t6_show", K_SHOW, 64'd1); push("t6_cnt", K_COUNT, 64'd0); drain();
        clk(1); push("t6_hexe", K_HEX, 64'(hp(0, BL, BL, BL, BL))); drain();
        clk(4); push("t6_onepage", K_PAGE, 64'd0); drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
